sad_min_select: RTL and testbench

Downstream consumer of the absolute-difference PE array in the motion-estimation core. Each cycle it takes one row of AD values (one per PE), reduces the row with a registered adder tree, and accumulates rows into a block SAD per candidate motion vector. Across a search window it tracks the minimum SAD and reports the winning candidate index to the motion-vector output stage.

---
 rtl/me_pkg.sv | 33 +++
 rtl/ad_adder_tree.sv | 35 +++
 rtl/sad_min_select.sv | 187 ++++++++++++++++++
 tb/tb_sad_min_select.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation SAD path: width derivations,
// default AD width and the selector FSM encoding.
package me_pkg;

  localparam int AD_W_DFLT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sad_st_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int row_w(input int ad_w, input int n_pe);
    return ad_w + clog2(n_pe);
  endfunction

  function automatic int sad_w(input int ad_w, input int n_pe, input int blk_rows);
    return row_w(ad_w, n_pe) + clog2(blk_rows);
  endfunction

  function automatic int cidx_w(input int n_cand);
    return clog2(n_cand);
  endfunction

endpackage

// File: rtl/ad_adder_tree.sv
// Unsigned N_PE-input reduction of one AD row, one register at the output.
module ad_adder_tree
  import me_pkg::*;
#(
  parameter int N_PE  = 16,
  parameter int AD_W  = AD_W_DFLT,
  parameter int ROW_W = row_w(AD_W, N_PE)
) (
  input  logic                   clk,
  input  logic [N_PE*AD_W-1:0]   ad_i,
  output logic [ROW_W-1:0]       row_sum_o
);

  // Heap layout: leaves at [N_PE-1 .. 2*N_PE-2], node i sums children 2i+1, 2i+2.
  logic [ROW_W-1:0] node [2*N_PE-1];
  logic [ROW_W-1:0] row_sum_d;
  logic [ROW_W-1:0] row_sum_q;

  always_comb begin
    for (int k = 0; k < N_PE; k++) begin
      node[N_PE-1+k] = ROW_W'(ad_i[k*AD_W +: AD_W]);
    end
    for (int i = N_PE - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
    row_sum_d = node[0];
  end

  always_ff @(posedge clk) begin
    row_sum_q <= row_sum_d;
  end

  assign row_sum_o = row_sum_q;

endmodule

// File: rtl/sad_min_select.sv
// Row reduction, per-candidate SAD accumulation and window-minimum tracking
// for the motion-estimation search.
module sad_min_select
  import me_pkg::*;
#(
  parameter int N_PE     = 16,
  parameter int BLK_ROWS = 16,
  parameter int N_CAND   = 32,
  parameter int AD_W     = AD_W_DFLT,
  localparam int ROW_W   = row_w(AD_W, N_PE),
  localparam int SAD_W   = sad_w(AD_W, N_PE, BLK_ROWS),
  localparam int CIDX_W  = cidx_w(N_CAND)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ad_valid,
  input  logic                  blk_start,
  input  logic [N_PE*AD_W-1:0]  ad_i,
  output logic                  sad_valid,
  output logic [SAD_W-1:0]      sad_o,
  output logic [CIDX_W-1:0]     sad_idx,
  output logic                  best_valid,
  output logic [SAD_W-1:0]      best_sad,
  output logic [CIDX_W-1:0]     best_idx
);

  localparam int RW = clog2(BLK_ROWS);

  sad_st_e             state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CIDX_W-1:0]   cand_q, cand_d;

  logic                beat_acc;
  logic [RW-1:0]       beat_row;
  logic [CIDX_W-1:0]   beat_cand;
  logic                beat_first, beat_last_row, beat_last_cand;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (beat_acc) begin
      state_d = (beat_last_row && beat_last_cand) ? ST_IDLE : ST_RUN;
    end
  end

  // blk_start overrides the counters, so an abort re-enters at row 0 / cand 0.
  always_comb begin
    beat_acc       = ad_valid && (blk_start || (state_q == ST_RUN));
    beat_row       = blk_start ? '0 : row_q;
    beat_cand      = blk_start ? '0 : cand_q;
    beat_first     = (beat_row == '0);
    beat_last_row  = (beat_row == RW'(BLK_ROWS - 1));
    beat_last_cand = (beat_cand == CIDX_W'(N_CAND - 1));
  end

  always_comb begin
    row_d  = row_q;
    cand_d = cand_q;
    if (beat_acc) begin
      row_d  = beat_last_row ? '0 : beat_row + 1'b1;
      cand_d = beat_last_row ? (beat_last_cand ? '0 : beat_cand + 1'b1) : beat_cand;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q  <= '0;
      cand_q <= '0;
    end else begin
      row_q  <= row_d;
      cand_q <= cand_d;
    end
  end

  // ---- Stage 1: row reduction, tags follow alongside ----
  logic [ROW_W-1:0]    row_sum_p1;
  logic                vld_p1_q, first_p1_q, last_p1_q, lastc_p1_q;
  logic [CIDX_W-1:0]   cand_p1_q;

  ad_adder_tree #(
    .N_PE  (N_PE),
    .AD_W  (AD_W),
    .ROW_W (ROW_W)
  ) u_tree (
    .clk       (clk),
    .ad_i      (ad_i),
    .row_sum_o (row_sum_p1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      lastc_p1_q <= 1'b0;
      cand_p1_q  <= '0;
    end else begin
      vld_p1_q   <= beat_acc;
      first_p1_q <= beat_first;
      last_p1_q  <= beat_last_row;
      lastc_p1_q <= beat_last_cand;
      cand_p1_q  <= beat_cand;
    end
  end

  // ---- Stage 2: candidate accumulation ----
  logic [SAD_W-1:0]    acc_q, acc_d;
  logic                sad_valid_q, sad_valid_d;
  logic [SAD_W-1:0]    sad_o_q, sad_o_d;
  logic [CIDX_W-1:0]   sad_idx_q, sad_idx_d;
  logic                lastc_p2_q, lastc_p2_d;

  always_comb begin
    acc_d = acc_q;
    if (vld_p1_q) begin
      acc_d = first_p1_q ? SAD_W'(row_sum_p1) : acc_q + SAD_W'(row_sum_p1);
    end
    sad_valid_d = vld_p1_q && last_p1_q;
    sad_o_d     = sad_valid_d ? acc_d     : sad_o_q;
    sad_idx_d   = sad_valid_d ? cand_p1_q : sad_idx_q;
    lastc_p2_d  = sad_valid_d && lastc_p1_q;
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sad_valid_q <= 1'b0;
      sad_o_q     <= '0;
      sad_idx_q   <= '0;
      lastc_p2_q  <= 1'b0;
    end else begin
      sad_valid_q <= sad_valid_d;
      sad_o_q     <= sad_o_d;
      sad_idx_q   <= sad_idx_d;
      lastc_p2_q  <= lastc_p2_d;
    end
  end

  // ---- Stage 3: window minimum ----
  // Candidate 0 always seeds the minimum, which also restarts it after an abort.
  logic [SAD_W-1:0]    min_q, min_d;
  logic [CIDX_W-1:0]   min_idx_q, min_idx_d;
  logic                best_valid_q, best_valid_d;
  logic [SAD_W-1:0]    best_sad_q, best_sad_d;
  logic [CIDX_W-1:0]   best_idx_q, best_idx_d;
  logic                min_upd;

  always_comb begin
    min_upd      = sad_valid_q && ((sad_idx_q == '0) || (sad_o_q < min_q));
    min_d        = min_upd ? sad_o_q   : min_q;
    min_idx_d    = min_upd ? sad_idx_q : min_idx_q;
    best_valid_d = lastc_p2_q;
    best_sad_d   = best_valid_d ? min_d     : best_sad_q;
    best_idx_d   = best_valid_d ? min_idx_d : best_idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_q        <= '0;
      min_idx_q    <= '0;
      best_valid_q <= 1'b0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
    end else begin
      min_q        <= min_d;
      min_idx_q    <= min_idx_d;
      best_valid_q <= best_valid_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
    end
  end

  assign sad_valid  = sad_valid_q;
  assign sad_o      = sad_o_q;
  assign sad_idx    = sad_idx_q;
  assign best_valid = best_valid_q;
  assign best_sad   = best_sad_q;
  assign best_idx   = best_idx_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Randomized bench for sad_min_select against a cycle-tagged expectation model.
module tb_sad_min_select;
  import me_pkg::*;

  localparam int N_PE     = 16;
  localparam int BLK_ROWS = 16;
  localparam int N_CAND   = 32;
  localparam int AD_W     = 8;
  localparam int SAD_W    = sad_w(AD_W, N_PE, BLK_ROWS);
  localparam int CIDX_W   = cidx_w(N_CAND);
  localparam int DW       = N_PE * AD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ad_valid = 1'b0;
  logic              blk_start = 1'b0;
  logic [DW-1:0]     ad_i = '0;
  logic              sad_valid, best_valid;
  logic [SAD_W-1:0]  sad_o, best_sad;
  logic [CIDX_W-1:0] sad_idx, best_idx;

  sad_min_select #(
    .N_PE(N_PE), .BLK_ROWS(BLK_ROWS), .N_CAND(N_CAND), .AD_W(AD_W)
  ) dut (
    .clk(clk), .rst(rst), .ad_valid(ad_valid), .blk_start(blk_start), .ad_i(ad_i),
    .sad_valid(sad_valid), .sad_o(sad_o), .sad_idx(sad_idx),
    .best_valid(best_valid), .best_sad(best_sad), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected pulses, each tagged with the cycle in which it must appear.
  typedef struct {
    int     cyc;
    longint val;
    int     idx;
  } exp_t;

  exp_t   sad_q[$];
  exp_t   best_q[$];
  exp_t   e_s, e_b;
  bit     m_active = 0;
  int     m_row = 0, m_cand = 0, m_min_idx = 0;
  longint m_acc = 0, m_min = 0;
  longint hold_sad = 0, hold_best = 0;
  int     hold_sidx = 0, hold_bidx = 0;

  task automatic model_beat(input bit st, input logic [DW-1:0] d, input int c);
    longint rs;
    rs = 0;
    if (st) begin
      m_active = 1;
      m_row    = 0;
      m_cand   = 0;
    end
    if (m_active) begin
      for (int k = 0; k < N_PE; k++) rs += longint'(d[k*AD_W +: AD_W]);
      m_acc = (m_row == 0) ? rs : m_acc + rs;
      if (m_row == BLK_ROWS - 1) begin
        sad_q.push_back('{c + 2, m_acc, m_cand});
        if (m_cand == 0 || m_acc < m_min) begin
          m_min     = m_acc;
          m_min_idx = m_cand;
        end
        if (m_cand == N_CAND - 1) begin
          best_q.push_back('{c + 3, m_min, m_min_idx});
          m_active = 0;
        end
        m_row = 0;
        m_cand++;
      end else begin
        m_row++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outs", {sad_valid, best_valid, sad_o, sad_idx, best_sad, best_idx}, 64'd0);
    end else begin
      if (sad_q.size() > 0 && sad_q[0].cyc == cyc) begin
        e_s = sad_q.pop_front();
        hold_sad  = e_s.val;
        hold_sidx = e_s.idx;
        chk("sad_valid_pulse", sad_valid, 1);
      end else begin
        chk("sad_valid_idle", sad_valid, 0);
      end
      chk("sad_o", sad_o, hold_sad);
      chk("sad_idx", sad_idx, hold_sidx);
      if (best_q.size() > 0 && best_q[0].cyc == cyc) begin
        e_b = best_q.pop_front();
        hold_best = e_b.val;
        hold_bidx = e_b.idx;
        chk("best_valid_pulse", best_valid, 1);
      end else begin
        chk("best_valid_idle", best_valid, 0);
      end
      chk("best_sad", best_sad, hold_best);
      chk("best_idx", best_idx, hold_bidx);
    end
  end

  task automatic beat(input bit v, input bit st, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    ad_valid  = v;
    blk_start = st;
    ad_i      = d;
    if (v) model_beat(st, d, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, '0);
  endtask

  function automatic logic [DW-1:0] gen(input int mode, input int cand);
    logic [DW-1:0] d;
    for (int k = 0; k < N_PE; k++) begin
      case (mode)
        0:       d[k*AD_W +: AD_W] = 8'd1;
        1:       d[k*AD_W +: AD_W] = (cand == 5) ? 8'd0 : 8'd3;
        2:       d[k*AD_W +: AD_W] = 8'd255;
        default: d[k*AD_W +: AD_W] = AD_W'($urandom_range(0, 255));
      endcase
    end
    return d;
  endfunction

  // Stops before driving beat (ac, ar) so the caller can replace it.
  task automatic run_window(input int mode, input int stall_pct, input int ac, input int ar);
    int ns;
    for (int c = 0; c < N_CAND; c++) begin
      for (int r = 0; r < BLK_ROWS; r++) begin
        if (c == ac && r == ar) return;
        ns = 0;
        while (ns < 4 && $urandom_range(0, 99) < stall_pct) begin
          beat(0, 1'($urandom_range(0, 1)), gen(3, 0));
          ns++;
        end
        beat(1, (c == 0 && r == 0), gen(mode, c));
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst       = 1'b0;
    ad_valid  = 1'b0;
    blk_start = 1'b0;
    sad_q.delete();
    best_q.delete();
    m_active  = 0;
    hold_sad  = 0;
    hold_sidx = 0;
    hold_best = 0;
    hold_bidx = 0;
    #1;
    chk("async_clear", {sad_valid, best_valid, sad_o, sad_idx, best_sad, best_idx}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Valid beats in IDLE without blk_start are ignored.
    for (int i = 0; i < 20; i++) beat(1, 0, gen(3, 0));
    idle(4);

    run_window(0, 0, -1, -1);   // all ones: 256 each, tie keeps index 0
    idle(4);
    run_window(1, 0, -1, -1);   // candidate 5 is the zero-SAD winner
    idle(4);
    run_window(2, 0, -1, -1);   // saturating-free maximum, 65280
    run_window(3, 0, -1, -1);   // back-to-back, no dead cycle
    idle(3);
    run_window(3, 50, -1, -1);  // 50% stalls
    idle(3);

    run_window(3, 0, 7, 9);     // abort at cand 7 row 9
    run_window(3, 0, -1, -1);
    idle(3);

    run_window(3, 0, N_CAND - 1, BLK_ROWS - 1);  // restart on the final beat
    run_window(3, 20, -1, -1);
    idle(3);

    run_window(3, 0, 10, 4);    // reset mid-window
    do_reset();
    for (int i = 0; i < 20; i++) beat(1, 0, gen(3, 0));
    idle(4);

    run_window(3, 30, -1, -1);
    idle(8);

    chk("sad_queue_drained", sad_q.size(), 0);
    chk("best_queue_drained", best_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
